// File: rtl/sqrt_share_arbiter.sv
// Round-robin share of one combinational integer square-root unit between NUM_REQ requesters.
// Optional macro SQRT_ARB_PIPE_EN adds a PIPE state and a second register stage on the results.
module sqrt_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned RAD_W   = 21,
  parameter int unsigned Q_W     = (RAD_W + 1) / 2,
  parameter int unsigned REM_W   = Q_W + 1,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_main,
  input  logic                     sys_rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*RAD_W-1:0] req_radical,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [Q_W-1:0]           rsp_q,
  output logic [REM_W-1:0]         rsp_rem,
  output logic                     busy
);

  localparam int unsigned RadExtW = 2 * Q_W;
  localparam int unsigned AccW    = REM_W + 2;

  typedef enum logic [1:0] {StIdle, StCalc, StPipe, StResp} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_id;
  logic [RAD_W-1:0] r_rad;
  logic [ID_W-1:0]  r_rsp_id;
  logic [Q_W-1:0]   r_rsp_q;
  logic [REM_W-1:0] r_rsp_rem;
`ifdef SQRT_ARB_PIPE_EN
  logic [Q_W-1:0]   r_p_q;
  logic [REM_W-1:0] r_p_rem;
`endif

  logic             w_found;
  logic [ID_W-1:0]  w_grant;
  logic             w_accept;
  logic [Q_W-1:0]   w_q;
  logic [REM_W-1:0] w_rem;

  // First valid requester after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_W-1:0] idx;
    w_found = 1'b0;
    w_grant = '0;
    idx     = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = ID_W'((int'(r_rr_ptr) + k) % int'(NUM_REQ));
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_grant = idx;
      end
    end
  end

  // Digit-by-digit restoring square root; the partial remainder never exceeds 2*root.
  always_comb begin
    logic [RadExtW-1:0] rad_ext;
    logic [AccW-1:0]    acc;
    logic [AccW-1:0]    trial;
    logic [Q_W-1:0]     root;
    rad_ext = RadExtW'(r_rad);
    acc     = '0;
    trial   = '0;
    root    = '0;
    for (int i = int'(Q_W) - 1; i >= 0; i--) begin
      acc   = {acc[AccW-3:0], rad_ext[2*i +: 2]};
      trial = AccW'({root, 2'b01});
      if (acc >= trial) begin
        acc  = acc - trial;
        root = {root[Q_W-2:0], 1'b1};
      end else begin
        root = {root[Q_W-2:0], 1'b0};
      end
    end
    w_q   = root;
    w_rem = acc[REM_W-1:0];
  end

  always_ff @(posedge clk_main or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_found) begin
          req_ready   = NUM_REQ'(1) << w_grant;
          w_accept    = 1'b1;
          w_state_nxt = StCalc;
        end
      end
`ifdef SQRT_ARB_PIPE_EN
      StCalc: w_state_nxt = StPipe;
`else
      StCalc: w_state_nxt = StResp;
`endif
      StPipe: w_state_nxt = StResp;
      StResp: begin
        if (rsp_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_main or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rr_ptr  <= ID_W'(NUM_REQ - 1);
      r_id      <= '0;
      r_rad     <= '0;
      r_rsp_id  <= '0;
      r_rsp_q   <= '0;
      r_rsp_rem <= '0;
`ifdef SQRT_ARB_PIPE_EN
      r_p_q     <= '0;
      r_p_rem   <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_rad    <= req_radical[int'(w_grant)*RAD_W +: RAD_W];
        r_id     <= w_grant;
        r_rr_ptr <= w_grant;
      end
`ifdef SQRT_ARB_PIPE_EN
      if (r_state == StCalc) begin
        r_p_q   <= w_q;
        r_p_rem <= w_rem;
      end
      if (r_state == StPipe) begin
        r_rsp_id  <= r_id;
        r_rsp_q   <= r_p_q;
        r_rsp_rem <= r_p_rem;
      end
`else
      if (r_state == StCalc) begin
        r_rsp_id  <= r_id;
        r_rsp_q   <= w_q;
        r_rsp_rem <= w_rem;
      end
`endif
    end
  end

  assign rsp_valid = (r_state == StResp);
  assign busy      = (r_state != StIdle);
  assign rsp_id    = r_rsp_id;
  assign rsp_q     = r_rsp_q;
  assign rsp_rem   = r_rsp_rem;

endmodule
